// File: rtl/spi_pkg.sv
// Shared definitions for the 3-byte SPI master/slave link: FSM encoding,
// frame ID bytes and the slave's register map.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_e;

    localparam logic [7:0] SLAVE_IDW_DEF = 8'hFF;
    localparam logic [7:0] SLAVE_IDR_DEF = 8'h00;

    localparam logic [7:0] REG_ADDR_0 = 8'h10;
    localparam logic [7:0] REG_ADDR_1 = 8'h11;
    localparam logic [7:0] REG_ADDR_2 = 8'h12;
    localparam logic [7:0] REG_ADDR_3 = 8'h13;

    localparam int FRAME_BITS = 24;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic is_reg_addr(input logic [7:0] a);
        return (a >= REG_ADDR_0) && (a <= REG_ADDR_3);
    endfunction

endpackage

// File: rtl/spi_master_tick.sv
// Loadable down-counter that times every SPI phase; tick_o marks the last
// cycle of the phase that was loaded.
module spi_master_tick #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             tick_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Loading N-1 on phase entry gives a phase exactly N cycles long.
    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master issuing 24-bit frames (ID, addr, data) to the team slave.
// Handshake: start is accepted only while the registered state is IDLE; busy
// is high from the next cycle until IDLE returns; done pulses once per frame.
module spi_master
    import spi_pkg::*;
#(
    parameter int         CLK_DIV   = 8,
    parameter int         SS_SETUP  = 4,
    parameter int         SS_GAP    = 8,
    parameter logic [7:0] SLAVE_IDW = SLAVE_IDW_DEF,
    parameter logic [7:0] SLAVE_IDR = SLAVE_IDR_DEF
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       ss,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output spi_state_e dbg_state
);

    localparam int DIV_MAX = max3(CLK_DIV, SS_SETUP, SS_GAP);
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DIV_W-1:0] LD_DIV   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LD_SETUP = DIV_W'(SS_SETUP - 1);
    localparam logic [DIV_W-1:0] LD_GAP   = DIV_W'(SS_GAP - 1);

    localparam logic [4:0] LAST_CNT  = 5'(FRAME_BITS);
    localparam logic [4:0] RX_FIRST  = 5'd16;

    spi_state_e  state_q, state_d;
    logic [23:0] tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic        rw_q, rw_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        ss_q, ss_d;
    logic        sclk_q, sclk_d;
    logic        busy_q, busy_d;

    logic             tick;
    logic             tick_load;
    logic [DIV_W-1:0] tick_val;
    logic             enter_high;

    spi_master_tick #(
        .WIDTH (DIV_W)
    ) u_tick (
        .clock      (clock),
        .n_reset    (n_reset),
        .load_i     (tick_load),
        .load_val_i (tick_val),
        .tick_o     (tick)
    );

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        tick_load  = 1'b0;
        tick_val   = '0;
        enter_high = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SETUP;
                    rw_d      = rw;
                    tx_d      = {rw ? SLAVE_IDR : SLAVE_IDW, addr, rw ? 8'h00 : wdata};
                    bit_cnt_d = '0;
                    tick_load = 1'b1;
                    tick_val  = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (tick) begin
                    state_d    = ST_HIGH;
                    tick_load  = 1'b1;
                    tick_val   = LD_DIV;
                    enter_high = 1'b1;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    state_d   = ST_LOW;
                    tick_load = 1'b1;
                    tick_val  = LD_DIV;
                    // Shifting a zero in leaves mosi low once all 24 bits are out.
                    tx_d      = {tx_q[22:0], 1'b0};
                    bit_cnt_d = (bit_cnt_q >= LAST_CNT) ? LAST_CNT : bit_cnt_q + 5'd1;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    tick_load = 1'b1;
                    if (bit_cnt_q < LAST_CNT) begin
                        state_d    = ST_HIGH;
                        tick_val   = LD_DIV;
                        enter_high = 1'b1;
                    end else begin
                        state_d  = ST_GAP;
                        tick_val = LD_GAP;
                        done_d   = 1'b1;
                        if (rw_q) begin
                            rdata_d = rx_q;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The slave has already settled miso for this bit, so the raw pin is
        // taken on the same edge that raises sclk.
        if (enter_high && rw_q && (bit_cnt_q >= RX_FIRST) && (bit_cnt_q < LAST_CNT)) begin
            rx_d = {rx_q[6:0], miso};
        end

        ss_d   = !(state_d inside {ST_SETUP, ST_HIGH, ST_LOW});
        sclk_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= ST_IDLE;
            tx_q      <= '0;
            rx_q      <= '0;
            bit_cnt_q <= '0;
            rw_q      <= 1'b0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            ss_q      <= 1'b1;
            sclk_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            ss_q      <= ss_d;
            sclk_q    <= sclk_d;
            busy_q    <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign ss        = ss_q;
    assign sclk      = sclk_q;
    assign mosi      = tx_q[23];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master.sv
// Randomised bench for spi_master: two instances (default timing and a fast
// CLK_DIV=4/SS_GAP=6 build), each attached to a behavioural register slave.
module tb_spi_master;
    import spi_pkg::*;

    logic clock = 1'b0;
    logic n_reset;

    logic [1:0] start_s;
    logic [1:0] rw_s;
    logic [7:0] addr_s [2];
    logic [7:0] wdata_s [2];
    logic [1:0] busy_w;
    logic [1:0] done_w;
    logic [7:0] rdata_w [2];
    logic [1:0] ss_w;
    logic [1:0] sclk_w;
    logic [1:0] mosi_w;
    logic [1:0] miso_r = 2'b00;
    spi_state_e state_w [2];

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q [$];
    logic [23:0] got_q [$];

    logic [7:0] ref_regs [2][4];
    logic [7:0] rdata_exp [2];

    logic [7:0] slv_regs [2][4] = '{default: 8'h00};
    int         sl_cnt [2];
    logic [23:0] sl_sh [2];
    logic [7:0] sl_rd [2];
    logic       sl_read [2];
    logic [1:0] ss_prev   = 2'b11;
    logic [1:0] sclk_prev = 2'b00;

    always #5 clock = ~clock;

    spi_master u_dut0 (
        .clock     (clock),
        .n_reset   (n_reset),
        .start     (start_s[0]),
        .rw        (rw_s[0]),
        .addr      (addr_s[0]),
        .wdata     (wdata_s[0]),
        .busy      (busy_w[0]),
        .done      (done_w[0]),
        .rdata     (rdata_w[0]),
        .ss        (ss_w[0]),
        .sclk      (sclk_w[0]),
        .mosi      (mosi_w[0]),
        .miso      (miso_r[0]),
        .dbg_state (state_w[0])
    );

    spi_master #(
        .CLK_DIV (4),
        .SS_GAP  (6)
    ) u_dut1 (
        .clock     (clock),
        .n_reset   (n_reset),
        .start     (start_s[1]),
        .rw        (rw_s[1]),
        .addr      (addr_s[1]),
        .wdata     (wdata_s[1]),
        .busy      (busy_w[1]),
        .done      (done_w[1]),
        .rdata     (rdata_w[1]),
        .ss        (ss_w[1]),
        .sclk      (sclk_w[1]),
        .mosi      (mosi_w[1]),
        .miso      (miso_r[1]),
        .dbg_state (state_w[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int p_div(input int inst);
        return (inst == 0) ? 8 : 4;
    endfunction

    function automatic int p_setup(input int inst);
        return (inst == 0) ? 4 : 4;
    endfunction

    function automatic int p_gap(input int inst);
        return (inst == 0) ? 8 : 6;
    endfunction

    // Behavioural slave: samples mosi on sclk rises, presents read data after
    // falls, and scrambles miso right after each rise.
    always @(sclk_w or ss_w) begin
        for (int g = 0; g < 2; g++) begin
            if (ss_prev[g] === 1'b1 && ss_w[g] === 1'b0) begin
                sl_cnt[g]  = 0;
                sl_sh[g]   = '0;
                sl_read[g] = 1'b0;
            end
            if (ss_w[g] === 1'b0 && sclk_prev[g] === 1'b0 && sclk_w[g] === 1'b1) begin
                sl_sh[g] = {sl_sh[g][22:0], mosi_w[g]};
                sl_cnt[g]++;
                if (sl_cnt[g] == 16) begin
                    sl_read[g] = (sl_sh[g][15:8] == SLAVE_IDR_DEF);
                    sl_rd[g]   = is_reg_addr(sl_sh[g][7:0]) ? slv_regs[g][sl_sh[g][1:0]] : 8'h00;
                end
                miso_r[g] = 1'($urandom_range(0, 1));
            end
            if (ss_w[g] === 1'b0 && sclk_prev[g] === 1'b1 && sclk_w[g] === 1'b0) begin
                if (sl_read[g] && sl_cnt[g] >= 16 && sl_cnt[g] <= 23) begin
                    miso_r[g] = sl_rd[g][3'(23 - sl_cnt[g])];
                end else begin
                    miso_r[g] = 1'($urandom_range(0, 1));
                end
            end
            if (ss_prev[g] === 1'b0 && ss_w[g] === 1'b1) begin
                if (sl_cnt[g] == 24) begin
                    got_q.push_back(sl_sh[g]);
                    if (sl_sh[g][23:16] == SLAVE_IDW_DEF && is_reg_addr(sl_sh[g][15:8])) begin
                        slv_regs[g][sl_sh[g][9:8]] = sl_sh[g][7:0];
                    end
                end
                sl_read[g] = 1'b0;
            end
        end
        ss_prev   = ss_w;
        sclk_prev = sclk_w;
    end

    // Caller must be positioned at a falling clock edge; start is raised in
    // that cycle and the task returns at the falling edge where busy is low.
    task automatic do_txn(input int inst, input logic rw, input logic [7:0] a,
                          input logic [7:0] wd, input logic glitch);
        logic [23:0] frame;
        int n, first_rise, done_n, ss_rise_n, busy_fall, pulses, dones, viol, bad;
        int exp_done, exp_fall;
        logic prev_sclk, prev_mosi;
        logic [7:0] rd_at_done;

        exp_done = p_setup(inst) + 1 + 2 * FRAME_BITS * p_div(inst);
        exp_fall = exp_done + p_gap(inst);
        frame = rw ? {SLAVE_IDR_DEF, a, 8'h00} : {SLAVE_IDW_DEF, a, wd};
        exp_q.push_back(frame);

        start_s[inst] = 1'b1;
        rw_s[inst]    = rw;
        addr_s[inst]  = a;
        wdata_s[inst] = wd;

        n = 0; first_rise = -1; done_n = -1; ss_rise_n = -1; busy_fall = -1;
        pulses = 0; dones = 0; viol = 0;
        prev_sclk = 1'b0; prev_mosi = 1'b0; rd_at_done = 8'hxx;
        while (busy_fall < 0 && n < 2000) begin
            @(negedge clock);
            n++;
            start_s[inst] = 1'b0;
            if (n == 1) begin
                chk("ss_low_t1", 32'(ss_w[inst]), 32'd0);
                chk("busy_t1", 32'(busy_w[inst]), 32'd1);
                chk("mosi_bit23_t1", 32'(mosi_w[inst]), 32'(frame[23]));
            end
            if (sclk_w[inst] && !prev_sclk) begin
                pulses++;
                if (first_rise < 0) first_rise = n;
            end
            if (mosi_w[inst] !== prev_mosi && sclk_w[inst]) viol++;
            if (done_w[inst]) begin
                dones++;
                if (done_n < 0) begin
                    done_n     = n;
                    rd_at_done = rdata_w[inst];
                end
            end
            if (ss_w[inst] && ss_rise_n < 0 && n > 1) ss_rise_n = n;
            if (!busy_w[inst]) busy_fall = n;
            prev_sclk = sclk_w[inst];
            prev_mosi = mosi_w[inst];
            if (glitch && busy_fall < 0 && (n == exp_done / 2 || n == exp_fall - 1)) begin
                start_s[inst] = 1'b1;
                rw_s[inst]    = 1'b0;
                addr_s[inst]  = 8'h13;
                wdata_s[inst] = 8'($urandom_range(0, 255));
            end
        end
        start_s[inst] = 1'b0;

        chk("first_sclk_rise", 32'(first_rise), 32'(p_setup(inst) + 1));
        chk("sclk_pulses", 32'(pulses), 32'(FRAME_BITS));
        chk("done_cycle", 32'(done_n), 32'(exp_done));
        chk("done_count", 32'(dones), 32'd1);
        chk("ss_rise_cycle", 32'(ss_rise_n), 32'(exp_done));
        chk("busy_fall_cycle", 32'(busy_fall), 32'(exp_fall));
        chk("mosi_change_while_sclk_high", 32'(viol), 32'd0);

        chk("frame_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            chk("frame_bits", 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();

        if (rw) begin
            rdata_exp[inst] = is_reg_addr(a) ? ref_regs[inst][a[1:0]] : 8'h00;
            chk("rdata_read", 32'(rd_at_done), 32'(rdata_exp[inst]));
        end else begin
            chk("rdata_kept_on_write", 32'(rd_at_done), 32'(rdata_exp[inst]));
            if (is_reg_addr(a)) ref_regs[inst][a[1:0]] = wd;
        end

        if (glitch) begin
            bad = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (busy_w[inst] || !ss_w[inst] || sclk_w[inst]) bad++;
            end
            chk("idle_after_ignored_start", 32'(bad), 32'd0);
            chk("no_extra_frame", 32'(got_q.size()), 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk({tag, "_ss"}, 32'(ss_w[i]), 32'd1);
            chk({tag, "_sclk"}, 32'(sclk_w[i]), 32'd0);
            chk({tag, "_mosi"}, 32'(mosi_w[i]), 32'd0);
            chk({tag, "_busy"}, 32'(busy_w[i]), 32'd0);
            chk({tag, "_done"}, 32'(done_w[i]), 32'd0);
            chk({tag, "_rdata"}, 32'(rdata_w[i]), 32'h00);
            chk({tag, "_state"}, 32'(state_w[i]), 32'(ST_IDLE));
        end
    endtask

    task automatic check_slave_regs(input int inst);
        for (int k = 0; k < 4; k++) begin
            chk("slave_reg", 32'(slv_regs[inst][k]), 32'(ref_regs[inst][k]));
        end
    endtask

    task automatic reset_mid_frame();
        int n, pulses;
        logic prev;
        start_s[0] = 1'b1;
        rw_s[0]    = 1'b0;
        addr_s[0]  = 8'h12;
        wdata_s[0] = 8'hE7;
        n = 0; pulses = 0; prev = 1'b0;
        while (pulses < 10 && n < 2000) begin
            @(negedge clock);
            n++;
            start_s[0] = 1'b0;
            if (sclk_w[0] && !prev) pulses++;
            prev = sclk_w[0];
        end
        chk("reset_reached_bit10", 32'(pulses), 32'd10);
        chk("reset_sclk_high_before", 32'(sclk_w[0]), 32'd1);
        n_reset = 1'b0;
        #1;
        check_reset_state("async_reset");
        rdata_exp[0] = 8'h00;
        rdata_exp[1] = 8'h00;
        @(negedge clock);
        @(negedge clock);
        n_reset = 1'b1;
        chk("reset_no_partial_frame", 32'(got_q.size()), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a, d;
        logic r;
        n_reset = 1'b0;
        start_s = '0;
        rw_s    = '0;
        for (int i = 0; i < 2; i++) begin
            addr_s[i]    = '0;
            wdata_s[i]   = '0;
            rdata_exp[i] = 8'h00;
            for (int k = 0; k < 4; k++) ref_regs[i][k] = 8'h00;
        end
        repeat (3) @(negedge clock);
        check_reset_state("por");
        n_reset = 1'b1;

        for (int i = 0; i < 2; i++) begin
            do_txn(i, 1'b0, 8'h12, 8'h3C, 1'b0);
            chk("slave_reg_0x12", 32'(slv_regs[i][2]), 32'(ref_regs[i][2]));

            do_txn(i, 1'b0, 8'h10, 8'hA5, 1'b0);
            do_txn(i, 1'b1, 8'h10, 8'h00, 1'b0);

            do_txn(i, 1'b0, 8'h11, 8'h5A, 1'b0);
            do_txn(i, 1'b1, 8'h20, 8'h00, 1'b0);
            chk("slave_reg_0x11", 32'(slv_regs[i][1]), 32'(ref_regs[i][1]));

            do_txn(i, 1'b0, 8'h12, 8'hC3, 1'b1);

            for (int k = 0; k < 4; k++) do_txn(i, 1'b0, 8'(16 + k), 8'(17 * (k + 1)), 1'b0);
            for (int k = 0; k < 4; k++) do_txn(i, 1'b1, 8'(16 + k), 8'h00, 1'b0);

            for (int t = 0; t < 10; t++) begin
                r = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 5))
                    0, 1, 2, 3: a = 8'(16 + $urandom_range(0, 3));
                    4:          a = 8'h20;
                    default:    a = 8'($urandom_range(0, 255));
                endcase
                d = 8'($urandom_range(0, 255));
                do_txn(i, r, a, d, 1'b0);
            end
            check_slave_regs(i);
        end

        do_txn(0, 1'b0, 8'h10, 8'h96, 1'b0);
        do_txn(0, 1'b1, 8'h10, 8'h00, 1'b0);
        reset_mid_frame();
        do_txn(0, 1'b0, 8'h13, 8'h77, 1'b0);
        do_txn(0, 1'b1, 8'h13, 8'h00, 1'b0);
        check_slave_regs(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
